// File: rtl/div_exec_unit.sv
// Iterative restoring divider behind the divide reservation station: queues issue packets,
// reads operands by tag, produces one quotient bit per cycle and pulses the DIV result bus.
module div_exec_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ITER  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [60:0]     issue_pkt,
    input  logic            exception_sig,
    input  logic            mret_sig,
    output logic [7:0]      rf_rs1_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    output logic [7:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic            DIV_result_valid,
    output logic [7:0]      DIV_result_dest,
    output logic [XLEN-1:0] DIV_result_data,
    output logic [31:0]     DIV_result_PC,
    output logic            div_busy,
    output logic            div_ovf_err,
    output logic [1:0]      dbg_state_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(ITER + 1);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CW-1:0]   ITER_CNT = CW'(ITER);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [59:0]     fifo_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [7:0]      rd_q, rd_d;
    logic [31:0]     pc_q, pc_d;

    logic            flush, pop, push_req, push_ok;
    logic [59:0]     head;
    logic            h_sgn, div0, sovf;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            qbit;
    logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;
    logic            unused_aluop_hi;

    assign flush    = reset | exception_sig | mret_sig;
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = (state_q == S_IDLE) && (count_q != '0) && !flush;
    assign push_req = issue_pkt[60] && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && ((count_q != FULL_CNT) || pop);

    assign rf_rs1_addr     = pop ? head[15:8] : 8'd0;
    assign rf_rs2_addr     = pop ? head[7:0]  : 8'd0;
    assign unused_aluop_hi = ^head[19:18];

    assign h_sgn = ~head[16];
    assign div0  = (rf_rs2_data == '0);
    assign sovf  = h_sgn && (rf_rs1_data == SMIN) && (rf_rs2_data == '1);
    assign abs_a = (h_sgn && rf_rs1_data[XLEN-1]) ? -rf_rs1_data : rf_rs1_data;
    assign abs_b = (h_sgn && rf_rs2_data[XLEN-1]) ? -rf_rs2_data : rf_rs2_data;

    // Partial remainder is one bit wider than the divisor so large unsigned divisors work.
    assign rem_shift = {rem_q, dvd_q[XLEN-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, dsr_q};
    assign qbit      = ~diff[XLEN+1];
    assign rem_step  = qbit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_step  = {dvd_q[XLEN-2:0], qbit};
    assign q_fix     = qneg_q ? -quo_step : quo_step;
    assign r_fix     = rneg_q ? -rem_step : rem_step;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        ovf_d    = ovf_q | (push_req & ~push_ok);
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    pc_d   = head[59:28];
                    rd_d   = head[27:20];
                    op_d   = head[17:16];
                    qneg_d = h_sgn & (rf_rs1_data[XLEN-1] ^ rf_rs2_data[XLEN-1]);
                    rneg_d = h_sgn & rf_rs1_data[XLEN-1];
                    dvd_d  = abs_a;
                    dsr_d  = abs_b;
                    rem_d  = '0;
                    cnt_d  = ITER_CNT;
                    if (div0) begin
                        res_d   = head[17] ? rf_rs1_data : '1;
                        state_d = S_DONE;
                    end else if (sovf) begin
                        res_d   = head[17] ? '0 : SMIN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_d   = op_q[1] ? r_fix : q_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush discards queued and in-flight work but keeps the sticky overflow flag.
        if (flush) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rd_q     <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= issue_pkt[59:0];
    end

    assign DIV_result_valid = (state_q == S_DONE);
    assign DIV_result_dest  = DIV_result_valid ? rd_q  : 8'd0;
    assign DIV_result_data  = DIV_result_valid ? res_q : '0;
    assign DIV_result_PC    = DIV_result_valid ? pc_q  : 32'd0;
    assign div_busy         = (state_q != S_IDLE) || (count_q != '0);
    assign div_ovf_err      = ovf_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_div_exec_unit.sv
// Directed bench for div_exec_unit: expected results (with their completion cycle) are queued
// at issue and matched by a monitor against every DIV_result_valid pulse.
module tb_div_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [60:0] issue_pkt;
    logic        exception_sig, mret_sig;
    logic [7:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        DIV_result_valid;
    logic [7:0]  DIV_result_dest;
    logic [31:0] DIV_result_data, DIV_result_PC;
    logic        div_busy, div_ovf_err;
    logic [1:0]  dbg_state;

    logic [31:0]  rf_mem [256];
    logic [103:0] exp_q [$];    // {cycle, pc, dest, data}
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [31:0]  next_pc = 32'h0000_2000;
    logic [7:0]   next_rd = 8'h20;

    div_exec_unit #(.DEPTH(4), .XLEN(32), .ITER(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .issue_pkt        (issue_pkt),
        .exception_sig    (exception_sig),
        .mret_sig         (mret_sig),
        .rf_rs1_addr      (rf_rs1_addr),
        .rf_rs1_data      (rf_rs1_data),
        .rf_rs2_addr      (rf_rs2_addr),
        .rf_rs2_data      (rf_rs2_data),
        .DIV_result_valid (DIV_result_valid),
        .DIV_result_dest  (DIV_result_dest),
        .DIV_result_data  (DIV_result_data),
        .DIV_result_PC    (DIV_result_PC),
        .div_busy         (div_busy),
        .div_ovf_err      (div_ovf_err),
        .dbg_state_o      (dbg_state)
    );

    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [103:0] e;
        if (!reset && DIV_result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got dest %h data %h at cycle %0d expected no pulse",
                         DIV_result_dest, DIV_result_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e[103:72]);
                chk("result_pc", DIV_result_PC, e[71:40]);
                chk("result_dest", {24'd0, DIV_result_dest}, {24'd0, e[39:32]});
                chk("result_data", DIV_result_data, e[31:0]);
            end
        end
    end

    // driver tasks: called at a negedge, drive one packet for one cycle
    task automatic send(input logic [31:0] pc, input logic [7:0] rd, input logic [3:0] op,
                        input logic [7:0] t1, input logic [7:0] t2, input logic [31:0] exp,
                        input int exp_cyc, input bit expect_it);
        issue_pkt = {1'b1, pc, rd, op, t1, t2};
        if (expect_it) exp_q.push_back({32'(exp_cyc), pc, rd, exp});
        @(negedge clk);
        issue_pkt = '0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (!div_busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy %0b pending %0d expected idle with nothing pending",
                     div_busy, exp_q.size());
        end
    endtask

    task automatic run_vec(input logic [3:0] op, input logic [7:0] t1, input logic [7:0] t2,
                           input logic [31:0] exp, input int lat);
        send(next_pc, next_rd, op, t1, t2, exp, cyc + lat, 1'b1);
        next_pc = next_pc + 32'd4;
        next_rd = next_rd + 8'd1;
        wait_idle(100);
    endtask

    initial begin : stimulus
        int c;
        for (int i = 0; i < 256; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'd100;
        rf_mem[2] = 32'd7;
        rf_mem[3] = 32'hFFFF_FFF9;
        rf_mem[4] = 32'd2;
        rf_mem[5] = 32'd5;
        rf_mem[6] = 32'd0;
        rf_mem[7] = 32'h8000_0000;
        rf_mem[8] = 32'hFFFF_FFFF;
        rf_mem[9] = 32'hFFFF_FFFE;
        issue_pkt     = '0;
        exception_sig = 1'b0;
        mret_sig      = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, DIV_result_valid}, 32'd0);
        chk("rst_busy", {31'd0, div_busy}, 32'd0);
        chk("rst_ovf", {31'd0, div_ovf_err}, 32'd0);
        chk("rst_rs1_addr", {24'd0, rf_rs1_addr}, 32'd0);
        chk("rst_data", DIV_result_data, 32'd0);
        reset = 1'b0;

        // DIVU 100/7 with operand-read address check on the pop cycle
        send(32'h0000_1000, 8'h11, 4'd1, 8'd1, 8'd2, 32'd14, cyc + 34, 1'b1);
        chk("pop_rs1_addr", {24'd0, rf_rs1_addr}, 32'd1);
        chk("pop_rs2_addr", {24'd0, rf_rs2_addr}, 32'd2);
        chk("pop_busy", {31'd0, div_busy}, 32'd1);
        @(negedge clk);
        chk("calc_rs1_addr", {24'd0, rf_rs1_addr}, 32'd0);
        chk("calc_busy", {31'd0, div_busy}, 32'd1);
        wait_idle(100);

        // normal divisions
        run_vec(4'd3,  8'd1, 8'd2, 32'd2,          34);  // REMU 100 % 7
        run_vec(4'd0,  8'd3, 8'd4, 32'hFFFF_FFFD,  34);  // DIV -7 / 2
        run_vec(4'd2,  8'd3, 8'd4, 32'hFFFF_FFFF,  34);  // REM -7 % 2
        run_vec(4'd3,  8'd3, 8'd4, 32'd1,          34);  // REMU 0xFFFFFFF9 % 2
        run_vec(4'd1,  8'd3, 8'd4, 32'h7FFF_FFFC,  34);  // DIVU 0xFFFFFFF9 / 2
        run_vec(4'd12, 8'd3, 8'd9, 32'd3,          34);  // DIV -7 / -2, upper ALUOP bits set
        run_vec(4'd2,  8'd3, 8'd9, 32'hFFFF_FFFF,  34);  // REM -7 % -2
        run_vec(4'd13, 8'd8, 8'd8, 32'd1,          34);  // DIVU max / max
        run_vec(4'd3,  8'd5, 8'd8, 32'd5,          34);  // REMU 5 % max
        run_vec(4'd0,  8'd7, 8'd5, 32'hE666_6667,  34);  // DIV MIN / 5
        run_vec(4'd2,  8'd7, 8'd5, 32'hFFFF_FFFD,  34);  // REM MIN % 5
        run_vec(4'd1,  8'd7, 8'd8, 32'd0,          34);  // DIVU 0x80000000 / max

        // special results: divide by zero and signed overflow
        run_vec(4'd1, 8'd5, 8'd6, 32'hFFFF_FFFF, 2);
        run_vec(4'd2, 8'd5, 8'd6, 32'd5,         2);
        run_vec(4'd0, 8'd3, 8'd6, 32'hFFFF_FFFF, 2);
        run_vec(4'd3, 8'd3, 8'd6, 32'hFFFF_FFF9, 2);
        run_vec(4'd0, 8'd7, 8'd8, 32'h8000_0000, 2);
        run_vec(4'd2, 8'd7, 8'd8, 32'd0,         2);

        // FIFO full: six back-to-back packets, the sixth is dropped
        c = cyc;
        send(32'h0000_3000, 8'h31, 4'd1, 8'd1, 8'd2, 32'd14,         c + 34,  1'b1);
        send(32'h0000_3004, 8'h32, 4'd3, 8'd1, 8'd2, 32'd2,          c + 68,  1'b1);
        send(32'h0000_3008, 8'h33, 4'd0, 8'd3, 8'd4, 32'hFFFF_FFFD,  c + 102, 1'b1);
        send(32'h0000_300C, 8'h34, 4'd2, 8'd3, 8'd9, 32'hFFFF_FFFF,  c + 136, 1'b1);
        chk("ovf_before_drop", {31'd0, div_ovf_err}, 32'd0);
        send(32'h0000_3010, 8'h35, 4'd1, 8'd8, 8'd8, 32'd1,          c + 170, 1'b1);
        send(32'h0000_3014, 8'h36, 4'd1, 8'd1, 8'd2, 32'd14,         c + 204, 1'b0);
        chk("ovf_after_drop", {31'd0, div_ovf_err}, 32'd1);
        wait_idle(400);

        // exception flush on cycle 10 of CALC with two packets queued
        send(32'h0000_4000, 8'h41, 4'd1, 8'd1, 8'd2, 32'd0, 0, 1'b0);
        send(32'h0000_4004, 8'h42, 4'd1, 8'd1, 8'd2, 32'd0, 0, 1'b0);
        send(32'h0000_4008, 8'h43, 4'd1, 8'd1, 8'd2, 32'd0, 0, 1'b0);
        repeat (8) @(negedge clk);
        exception_sig = 1'b1;
        @(negedge clk);
        exception_sig = 1'b0;
        chk("flush_busy", {31'd0, div_busy}, 32'd0);
        chk("flush_valid", {31'd0, DIV_result_valid}, 32'd0);
        chk("flush_ovf_held", {31'd0, div_ovf_err}, 32'd1);
        repeat (40) @(negedge clk);
        chk("flush_idle_later", {31'd0, div_busy}, 32'd0);
        run_vec(4'd2, 8'd3, 8'd4, 32'hFFFF_FFFF, 34);

        // mret during DONE: the present pulse stands, the queued packet is discarded
        send(32'h0000_5000, 8'h51, 4'd1, 8'd5, 8'd6, 32'hFFFF_FFFF, cyc + 2, 1'b1);
        send(32'h0000_5004, 8'h52, 4'd2, 8'd5, 8'd6, 32'd5, 0, 1'b0);
        mret_sig = 1'b1;
        @(negedge clk);
        mret_sig = 1'b0;
        chk("mret_busy", {31'd0, div_busy}, 32'd0);
        chk("mret_ovf_held", {31'd0, div_ovf_err}, 32'd1);
        repeat (10) @(negedge clk);

        // reset during CALC with the overflow flag set
        send(32'h0000_6000, 8'h61, 4'd1, 8'd1, 8'd2, 32'd0, 0, 1'b0);
        send(32'h0000_6004, 8'h62, 4'd1, 8'd1, 8'd2, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("ovf_before_reset", {31'd0, div_ovf_err}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, div_busy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, div_ovf_err}, 32'd0);
        chk("mid_rst_valid", {31'd0, DIV_result_valid}, 32'd0);
        chk("mid_rst_rs1_addr", {24'd0, rf_rs1_addr}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_fifo_empty", {31'd0, div_busy}, 32'd0);
        run_vec(4'd1, 8'd1, 8'd2, 32'd14, 34);

        chk("pending_left", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_exec_unit.md
Name: div_exec_unit

Overview:
- Iterative 32-bit integer divide execution unit.
- Sits directly downstream of the divide reservation station and consumes its 61-bit issue packet.
- Reads source operands from the physical register file by tag.
- Computes DIV/DIVU/REM/REMU and broadcasts completion on the DIV result bus. The reservation stations use that bus for operand wakeup.

Parameters:
- DEPTH, 4: issue FIFO entries; must be a power of 2, at least 2.
- XLEN, 32: operand and result width.
- ITER, 32: division iterations, one quotient bit per cycle; must equal XLEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- issue_pkt  in  61  packet {valid[60], PC[59:28], Rd[27:20], ALUOP[19:16], op1_tag[15:8], op2_tag[7:0]}.
- exception_sig  in  1  pipeline flush.
- mret_sig  in  1  pipeline flush.
- rf_rs1_addr  out  8  physical register read address for the dividend.
- rf_rs1_data  in  32  combinational read data for the dividend.
- rf_rs2_addr  out  8  physical register read address for the divisor.
- rf_rs2_data  in  32  combinational read data for the divisor.
- DIV_result_valid  out  1  one-cycle completion pulse.
- DIV_result_dest  out  8  destination physical register (Rd).
- DIV_result_data  out  32  quotient or remainder.
- DIV_result_PC  out  32  PC of the completing instruction.
- div_busy  out  1  FSM not IDLE, or FIFO non-empty.
- div_ovf_err  out  1  sticky flag: an issue packet was dropped on a full FIFO.

Behaviour:
- Reset, or exception_sig or mret_sig (flush, same priority as reset):
  - FIFO emptied (rd_ptr = wr_ptr = 0, count = 0); FSM goes to IDLE.
  - All outputs go to 0, except div_ovf_err, which is cleared by reset only and holds across flush.
  - An in-flight division is aborted and produces no result pulse.
- FIFO push:
  - issue_pkt[60]=1 pushes bits [59:0].
  - Push and pop in the same cycle is legal, including when the FIFO is full.
  - Push while full with no pop that cycle: packet dropped, div_ovf_err set to 1.
  - Pointers wrap modulo DEPTH.
- ALUOP[1:0] selects the operation: 0 = DIV (signed), 1 = DIVU, 2 = REM (signed), 3 = REMU. ALUOP[3:2] is ignored.
- FSM states: IDLE, CALC, DONE.
  - IDLE with FIFO non-empty:
    - rf_rs1_addr/rf_rs2_addr are driven from the head op1_tag/op2_tag in the same cycle; the head is popped.
    - Operands, Rd, PC and op are latched at the clock edge.
    - Divisor == 0 or signed overflow: go to DONE with the special result.
    - Otherwise: take magnitudes when the op is signed; load a shift/subtract datapath with counter = ITER; go to CALC.
  - rf_*_addr are 0 whenever no pop occurs.
  - CALC:
    - Each cycle: remainder = {remainder, dividend MSB}; subtract the divisor if the result is non-negative; shift the quotient bit in; counter decrements.
    - Counter reaching 0 at the end of a cycle: apply sign fix-up, go to DONE.
  - DONE:
    - DIV_result_valid=1 for exactly this cycle, with dest/data/PC held.
    - Next state is IDLE; no pop occurs in DONE.
    - Outputs return to 0 the following cycle.
- Latency:
  - Normal: DIV_result_valid is asserted 33 cycles after the pop cycle (32 CALC + 1).
  - Special case: asserted 1 cycle after the pop cycle.
- Throughput: one op per 34 cycles (normal) or per 2 cycles (special).
- Signed fix-up:
  - Quotient is negated if the dividend sign differs from the divisor sign.
  - Remainder takes the dividend's sign.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Flush asserted during DONE: the pulse already present that cycle stands. No further pulse occurs, and state becomes IDLE.
- The register file read reflects writes completed in earlier cycles. The RS issues only ready operands, so no bypass is needed.

Test Plan:
- DIVU: tags hold 100 and 7 → DIV_result_valid pulse 33 cycles after the pop, data = 14 (0x0000000E), dest = Rd, PC echoed.
- DIV/REM: -7 (0xFFFFFFF9) / 2 → DIV data = 0xFFFFFFFD; REM data = 0xFFFFFFFF; REMU 0xFFFFFFF9 % 2 = 1.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each pulse 1 cycle after the pop; overflow DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- FIFO full: DEPTH=4, 6 back-to-back valid packets → the first pops immediately and 4 are queued, so 1 is dropped; div_ovf_err=1; exactly 5 result pulses, in order, each 34 cycles apart.
- Flush mid-CALC: exception_sig at cycle 10 of CALC with 2 queued → no pulse, div_busy=0 next cycle, div_ovf_err unchanged, and a following packet completes normally.
- Reset mid-operation: reset during CALC with div_ovf_err=1 → all outputs 0 including div_ovf_err; FIFO empty.
